// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame core: parity encodings, frame FSM
// states and oversampling constants used by both TX and RX.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } frame_state_t;

  // Mode 11 is reserved and behaves as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// UART receiver: input synchroniser, 16x oversampled frame FSM with
// mid-bit sampling, parity/framing/break status.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ce_16,
  input  logic [1:0]           par_mode,
  input  logic                 stop2,
  input  logic                 ser_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 new_rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_break
);

  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_bit;
  frame_state_t           state_reg;
  logic [TICK_W-1:0]      tick_reg;
  logic [3:0]             bit_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_acc_reg, zero_reg, stop1_bad_reg, brk_hold_reg;
  logic                   par_en_reg, odd_reg, two_stop_reg, armed_reg;
  logic                   fin, fin_ferr, fin_brk;

  assign rx_bit = sync_reg[SYNC_STAGES-1];

  always_comb begin
    fin      = ce_16 && (tick_reg == TICK_MID) &&
               (((state_reg == ST_STOP1) && !two_stop_reg) || (state_reg == ST_STOP2));
    fin_ferr = !rx_bit || ((state_reg == ST_STOP2) && stop1_bad_reg);
    fin_brk  = (state_reg == ST_STOP2) ? brk_hold_reg : (zero_reg && !rx_bit);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg      <= '1;
      state_reg     <= ST_IDLE;
      tick_reg      <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      par_acc_reg   <= 1'b0;
      zero_reg      <= 1'b0;
      stop1_bad_reg <= 1'b0;
      brk_hold_reg  <= 1'b0;
      par_en_reg    <= 1'b0;
      odd_reg       <= 1'b0;
      two_stop_reg  <= 1'b0;
      armed_reg     <= 1'b1;
      rx_data       <= '0;
      new_rx_data   <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], ser_in};
      new_rx_data <= 1'b0;
      if (ce_16) begin
        if (state_reg == ST_IDLE) begin
          if (rx_bit) begin
            armed_reg <= 1'b1;
          end else if (armed_reg) begin
            // The detecting ce_16 is the first of the start bit.
            state_reg    <= ST_START;
            tick_reg     <= TICK_W'(1);
            bit_reg      <= '0;
            par_acc_reg  <= 1'b0;
            zero_reg     <= 1'b1;
            par_en_reg   <= parity_enabled(par_mode);
            odd_reg      <= (par_mode == PAR_ODD);
            two_stop_reg <= stop2;
          end
        end else begin
          tick_reg <= tick_reg + 1'b1;
          if (tick_reg == TICK_MID) begin
            case (state_reg)
              ST_START: if (rx_bit) state_reg <= ST_IDLE;
              ST_DATA: begin
                shift_reg   <= {rx_bit, shift_reg[DATA_BITS-1:1]};
                par_acc_reg <= par_acc_reg ^ rx_bit;
                zero_reg    <= zero_reg & ~rx_bit;
              end
              ST_PARITY: begin
                par_acc_reg <= par_acc_reg ^ rx_bit;
                zero_reg    <= zero_reg & ~rx_bit;
              end
              ST_STOP1: if (two_stop_reg) begin
                stop1_bad_reg <= !rx_bit;
                brk_hold_reg  <= zero_reg && !rx_bit;
              end
              default: ;
            endcase
          end else if (tick_reg == TICK_LAST) begin
            case (state_reg)
              ST_START: state_reg <= ST_DATA;
              ST_DATA: begin
                if (bit_reg == BIT_LAST) state_reg <= par_en_reg ? ST_PARITY : ST_STOP1;
                else                     bit_reg   <= bit_reg + 1'b1;
              end
              ST_PARITY: state_reg <= ST_STOP1;
              ST_STOP1:  state_reg <= ST_STOP2;
              default:   state_reg <= ST_IDLE;
            endcase
          end
        end
      end
      if (fin) begin
        state_reg   <= ST_IDLE;
        new_rx_data <= 1'b1;
        rx_data     <= shift_reg;
        parity_err  <= par_en_reg && (par_acc_reg ^ odd_reg);
        frame_err   <= fin_ferr;
        rx_break    <= fin_brk;
        armed_reg   <= !fin_ferr;
      end
    end
  end

endmodule

// File: rtl/uart_frame_core.sv
// UART frame core: inline transmitter FSM plus the uart_rx_frame receiver,
// both paced by a shared 16x bit-rate clock enable.
module uart_frame_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ce_16,
  input  logic [1:0]           par_mode,
  input  logic                 stop2,
  input  logic                 ser_in,
  output logic                 ser_out,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 new_tx_data,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 new_rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_break
);

  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

  frame_state_t         tx_state_reg;
  logic [TICK_W-1:0]    tx_tick_reg;
  logic [3:0]           tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_bit_reg, tx_par_en_reg, tx_stop2_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_reg   <= ST_IDLE;
      tx_tick_reg    <= '0;
      tx_bit_reg     <= '0;
      tx_shift_reg   <= '0;
      tx_par_bit_reg <= 1'b0;
      tx_par_en_reg  <= 1'b0;
      tx_stop2_reg   <= 1'b0;
      ser_out        <= 1'b1;
      tx_busy        <= 1'b0;
    end else if (tx_state_reg == ST_IDLE) begin
      if (new_tx_data) begin
        tx_shift_reg   <= tx_data;
        tx_par_bit_reg <= (^tx_data) ^ (par_mode == PAR_ODD);
        tx_par_en_reg  <= parity_enabled(par_mode);
        tx_stop2_reg   <= stop2;
        tx_tick_reg    <= '0;
        tx_bit_reg     <= '0;
        ser_out        <= 1'b0;
        tx_busy        <= 1'b1;
        tx_state_reg   <= ST_START;
      end
    end else if (ce_16) begin
      tx_tick_reg <= tx_tick_reg + 1'b1;
      if (tx_tick_reg == TICK_LAST) begin
        case (tx_state_reg)
          ST_START: begin
            tx_state_reg <= ST_DATA;
            ser_out      <= tx_shift_reg[0];
          end
          ST_DATA: begin
            if (tx_bit_reg == BIT_LAST) begin
              tx_state_reg <= tx_par_en_reg ? ST_PARITY : ST_STOP1;
              ser_out      <= tx_par_en_reg ? tx_par_bit_reg : 1'b1;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 1'b1;
              tx_shift_reg <= tx_shift_reg >> 1;
              ser_out      <= tx_shift_reg[1];
            end
          end
          ST_PARITY: begin
            tx_state_reg <= ST_STOP1;
            ser_out      <= 1'b1;
          end
          ST_STOP1: begin
            if (tx_stop2_reg) begin
              tx_state_reg <= ST_STOP2;
            end else begin
              tx_state_reg <= ST_IDLE;
              tx_busy      <= 1'b0;
            end
          end
          default: begin
            tx_state_reg <= ST_IDLE;
            tx_busy      <= 1'b0;
            ser_out      <= 1'b1;
          end
        endcase
      end
    end
  end

  uart_rx_frame #(
    .DATA_BITS  (DATA_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .ce_16      (ce_16),
    .par_mode   (par_mode),
    .stop2      (stop2),
    .ser_in     (ser_in),
    .rx_data    (rx_data),
    .new_rx_data(new_rx_data),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_break   (rx_break)
  );

endmodule

// File: tb/tb_uart_frame_core.sv
// Directed bench: an 8-bit core (loopback or driven line) and a 7-bit core
// for back-to-back transmit and mid-frame reset.
module tb_uart_frame_core;

  logic       clock = 1'b0;
  logic       reset, ce_16, stop2, loop_en, drv_in;
  logic [1:0] par_mode;

  logic [7:0] tx_data8, rx_data8;
  logic       new_tx8, ser_out8, ser_in8, busy8, new_rx8, perr8, ferr8, brk8;
  logic [6:0] tx_data7, rx_data7;
  logic       new_tx7, ser_out7, busy7, new_rx7, perr7, ferr7, brk7;

  int total = 0, passed = 0, pulses8 = 0, pulses7 = 0;

  always #5 clock = ~clock;
  assign ser_in8 = loop_en ? ser_out8 : drv_in;

  uart_frame_core #(.DATA_BITS(8), .SYNC_STAGES(2)) dut8 (
    .clock(clock), .reset(reset), .ce_16(ce_16), .par_mode(par_mode), .stop2(stop2),
    .ser_in(ser_in8), .ser_out(ser_out8), .tx_data(tx_data8), .new_tx_data(new_tx8),
    .tx_busy(busy8), .rx_data(rx_data8), .new_rx_data(new_rx8), .parity_err(perr8),
    .frame_err(ferr8), .rx_break(brk8)
  );

  uart_frame_core #(.DATA_BITS(7), .SYNC_STAGES(3)) dut7 (
    .clock(clock), .reset(reset), .ce_16(ce_16), .par_mode(par_mode), .stop2(stop2),
    .ser_in(ser_out7), .ser_out(ser_out7), .tx_data(tx_data7), .new_tx_data(new_tx7),
    .tx_busy(busy7), .rx_data(rx_data7), .new_rx_data(new_rx7), .parity_err(perr7),
    .frame_err(ferr7), .rx_break(brk7)
  );

  always @(negedge clock) begin
    if (new_rx8 === 1'b1) pulses8++;
    if (new_rx7 === 1'b1) pulses7++;
  end

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pm;
    logic        s2;
    logic [11:0] frame;
    int          len;
  } tx_vec_t;

  tx_vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic drive_bits(input logic [11:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      drv_in = bits[i];
      repeat (16) @(negedge clock);
    end
    drv_in = 1'b1;
  endtask

  task automatic run_vec(input tx_vec_t v);
    logic [11:0] cap;
    int c, busy, p0;
    @(negedge clock);
    tx_data8 = v.data; par_mode = v.pm; stop2 = v.s2; new_tx8 = 1'b1;
    @(negedge clock);
    new_tx8 = 1'b0;
    p0 = pulses8; cap = '0; busy = 0; c = 0;
    while (busy8 && c < 400) begin
      if (c % 16 == 8 && c / 16 < 12) cap[c/16] = ser_out8;
      if (c == 32) begin par_mode = par_mode ^ 2'b01; stop2 = ~stop2; end
      busy++; c++;
      @(negedge clock);
    end
    repeat (10) @(negedge clock);
    $display("tx %02h mode %0d stop2 %0d: frame %03h busy %0d rx %02h p%0d f%0d b%0d",
             v.data, v.pm, v.s2, cap, busy, rx_data8, perr8, ferr8, brk8);
    check("tx_frame", cap, v.frame);
    check("tx_busy_len", busy, v.len * 16);
    check("rx_pulses", pulses8 - p0, 1);
    check("rx_data", rx_data8, v.data);
    check("parity_err", perr8, 0);
    check("frame_err", ferr8, 0);
    check("rx_break", brk8, 0);
  endtask

  initial begin
    logic [11:0] cap;
    int c, busy, p0;

    vecs[0] = '{8'hA5, 2'b00, 1'b0, 12'h34A, 10};
    vecs[1] = '{8'h07, 2'b01, 1'b1, 12'hE0E, 12};
    vecs[2] = '{8'h3C, 2'b10, 1'b0, 12'h678, 11};
    vecs[3] = '{8'h00, 2'b01, 1'b0, 12'h400, 11};
    vecs[4] = '{8'hFF, 2'b11, 1'b1, 12'h7FE, 11};

    reset = 1'b0; ce_16 = 1'b1; stop2 = 1'b0; par_mode = 2'b00; loop_en = 1'b1; drv_in = 1'b1;
    tx_data8 = '0; new_tx8 = 1'b0; tx_data7 = '0; new_tx7 = 1'b0;
    repeat (3) @(negedge clock);
    $display("reset: ser_out %0d busy %0d rx %02h", ser_out8, busy8, rx_data8);
    check("rst_ser_out", ser_out8, 1);
    check("rst_tx_busy", busy8, 0);
    check("rst_new_rx", new_rx8, 0);
    check("rst_rx_data", rx_data8, 0);
    check("rst_parity_err", perr8, 0);
    check("rst_frame_err", ferr8, 0);
    check("rst_rx_break", brk8, 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Odd parity, 0x3C with the parity bit forced wrong.
    loop_en = 1'b0; par_mode = 2'b10; stop2 = 1'b0;
    @(negedge clock);
    p0 = pulses8;
    drive_bits(12'h478, 11);
    repeat (6) @(negedge clock);
    $display("rx bad parity: rx %02h p%0d f%0d b%0d", rx_data8, perr8, ferr8, brk8);
    check("badpar_pulses", pulses8 - p0, 1);
    check("badpar_rx_data", rx_data8, 8'h3C);
    check("badpar_parity_err", perr8, 1);
    check("badpar_frame_err", ferr8, 0);
    check("badpar_rx_break", brk8, 0);

    // Short low glitch is rejected without touching status.
    par_mode = 2'b00;
    p0 = pulses8;
    drv_in = 1'b0;
    repeat (4) @(negedge clock);
    drv_in = 1'b1;
    repeat (40) @(negedge clock);
    $display("rx glitch: pulses %0d p%0d", pulses8 - p0, perr8);
    check("glitch_pulses", pulses8 - p0, 0);
    check("glitch_parity_hold", perr8, 1);
    drive_bits(12'h2B4, 10);
    repeat (6) @(negedge clock);
    $display("rx after glitch: rx %02h p%0d", rx_data8, perr8);
    check("post_glitch_pulses", pulses8 - p0, 1);
    check("post_glitch_rx_data", rx_data8, 8'h5A);
    check("post_glitch_parity_err", perr8, 0);

    // Break: line low for 12 bit times, then 10 more, then released.
    p0 = pulses8;
    drv_in = 1'b0;
    repeat (12 * 16) @(negedge clock);
    $display("rx break: pulses %0d rx %02h f%0d b%0d", pulses8 - p0, rx_data8, ferr8, brk8);
    check("break_pulses", pulses8 - p0, 1);
    check("break_rx_data", rx_data8, 0);
    check("break_frame_err", ferr8, 1);
    check("break_rx_break", brk8, 1);
    repeat (10 * 16) @(negedge clock);
    check("break_no_rearm", pulses8 - p0, 1);
    drv_in = 1'b1;
    repeat (40) @(negedge clock);
    drive_bits(12'h2B4, 10);
    repeat (6) @(negedge clock);
    $display("rx after break: pulses %0d rx %02h f%0d b%0d", pulses8 - p0, rx_data8, ferr8, brk8);
    check("rearm_pulses", pulses8 - p0, 2);
    check("rearm_rx_data", rx_data8, 8'h5A);
    check("rearm_frame_err", ferr8, 0);
    check("rearm_rx_break", brk8, 0);

    // 7-bit core: back-to-back frames, then reset mid-second-frame.
    par_mode = 2'b00; stop2 = 1'b1;
    p0 = pulses7;
    @(negedge clock);
    tx_data7 = 7'h55; new_tx7 = 1'b1;
    @(negedge clock);
    new_tx7 = 1'b0;
    cap = '0; busy = 0; c = 0;
    while (busy7 && c < 400) begin
      if (c % 16 == 8 && c / 16 < 12) cap[c/16] = ser_out7;
      busy++; c++;
      @(negedge clock);
    end
    tx_data7 = 7'h2A; new_tx7 = 1'b1;
    @(negedge clock);
    new_tx7 = 1'b0;
    $display("tx7 55: frame %03h busy %0d rx %02h; b2b busy %0d ser_out %0d",
             cap, busy, rx_data7, busy7, ser_out7);
    check("b2b_frame1", cap, 12'h3AA);
    check("b2b_busy_len", busy, 160);
    check("b2b_rx_data", rx_data7, 7'h55);
    check("b2b_rx_pulses", pulses7 - p0, 1);
    check("b2b_busy_restart", busy7, 1);
    check("b2b_start_bit", ser_out7, 0);
    cap = '0;
    for (int k = 0; k < 50; k++) begin
      if (k % 16 == 8) cap[k/16] = ser_out7;
      @(negedge clock);
    end
    check("b2b_frame2_head", cap[2:0], 3'b100);
    #2 reset = 1'b0;
    #1;
    $display("reset mid-frame: ser_out %0d busy %0d", ser_out7, busy7);
    check("abort_ser_out", ser_out7, 1);
    check("abort_tx_busy", busy7, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (200) @(negedge clock);
    $display("after abort: rx pulses %0d rx %02h", pulses7 - p0, rx_data7);
    check("abort_no_rx_pulse", pulses7 - p0, 1);
    check("abort_rx_data", rx_data7, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
